// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler that shares one UART sender among N_REQ requesters.
// Frame timing is owned here because the sender gives no busy indication.
//
// state  | meaning
// S_IDLE | waiting for enable and a request; nothing is being sent
// S_SEND | send_flag held high for FRAME_CLKS cycles with the latched character
// S_GAP  | send_flag low for max(GAP_CLKS,1) cycles; ack pulses in the first cycle
module uart_tx_arbiter #(
  parameter int N_REQ      = 4,
  parameter int FRAME_CLKS = 20850,
  parameter int GAP_CLKS   = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic [N_REQ-1:0]     req,
  input  logic [7*N_REQ-1:0]   req_data,
  output logic [N_REQ-1:0]     ack,
  output logic [N_REQ-1:0]     grant,
  output logic                 send_flag,
  output logic [6:0]           send_data,
  output logic                 busy
);

  localparam int GAP_EFF = (GAP_CLKS < 1) ? 1 : GAP_CLKS;
  localparam int CW_F    = $clog2(FRAME_CLKS + 1);
  localparam int CW_G    = $clog2(GAP_EFF + 1);
  localparam int CW      = (CW_F > CW_G) ? CW_F : CW_G;
  localparam int IDXW    = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [IDXW-1:0]   rr_q, rr_d;
  logic [N_REQ-1:0]  grant_q, grant_d;
  logic [N_REQ-1:0]  ack_q, ack_d;
  logic              flag_q, flag_d;
  logic [6:0]        data_q, data_d;
  logic              busy_q, busy_d;

  logic [6:0]        chars [N_REQ];
  logic              found;
  logic [IDXW-1:0]   win;
  logic [N_REQ-1:0]  win_oh;

  for (genvar i = 0; i < N_REQ; i++) begin : g_chars
    assign chars[i] = req_data[7*i +: 7];
  end

  // Circular search starting just after the last winner.
  always_comb begin
    found = 1'b0;
    win   = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      int s;
      s = int'(rr_q) + k;
      if (s >= N_REQ) s = s - N_REQ;
      if (!found && req[IDXW'(s)]) begin
        found = 1'b1;
        win   = IDXW'(s);
      end
    end
  end

  assign win_oh = {{(N_REQ-1){1'b0}}, 1'b1} << win;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rr_d    = rr_q;
    grant_d = grant_q;
    ack_d   = '0;
    flag_d  = flag_q;
    data_d  = data_q;
    busy_d  = busy_q;
    case (state_q)
      S_IDLE: begin
        if (enable && found) begin
          state_d = S_SEND;
          grant_d = win_oh;
          data_d  = chars[win];
          flag_d  = 1'b1;
          busy_d  = 1'b1;
          rr_d    = win;
          cnt_d   = '0;
        end
      end
      S_SEND: begin
        if (cnt_q == CW'(FRAME_CLKS - 1)) begin
          state_d = S_GAP;
          flag_d  = 1'b0;
          grant_d = '0;
          ack_d   = grant_q;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_GAP: begin
        if (cnt_q == CW'(GAP_EFF - 1)) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        grant_d = '0;
        flag_d  = 1'b0;
        busy_d  = 1'b0;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rr_q    <= IDXW'(N_REQ - 1);
      grant_q <= '0;
      ack_q   <= '0;
      flag_q  <= 1'b0;
      data_q  <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rr_q    <= rr_d;
      grant_q <= grant_d;
      ack_q   <= ack_d;
      flag_q  <= flag_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
    end
  end

  assign ack       = ack_q;
  assign grant     = grant_q;
  assign send_flag = flag_q;
  assign send_data = data_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: timeline reference model (frame start time + offsets),
// directed scenarios with literal expectations, then randomized traffic.
module tb_uart_tx_arbiter;

  localparam int N = 4;
  localparam int F = 8;
  localparam int G = 2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             enable = 1'b0;
  logic [N-1:0]     req = '0;
  logic [7*N-1:0]   req_data = '0;
  logic [N-1:0]     ack, grant;
  logic             send_flag;
  logic [6:0]       send_data;
  logic             busy;

  uart_tx_arbiter #(.N_REQ(N), .FRAME_CLKS(F), .GAP_CLKS(G)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .req(req), .req_data(req_data),
    .ack(ack), .grant(grant), .send_flag(send_flag), .send_data(send_data), .busy(busy)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Model: a frame is fully described by its start edge t0 and winner.
  int        n = 0;
  int        t0 = 0;
  bit        active = 1'b0;
  int        rr = N - 1;
  int        m_win = 0;
  logic [6:0] m_data = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at edge %0d: got %0h expected %0h", name, n, act, exp);
    end
  endtask

  task automatic model_reset();
    active = 1'b0;
    rr     = N - 1;
    m_data = '0;
  endtask

  task automatic model_edge(input logic en, input logic [N-1:0] rq, input logic [7*N-1:0] dat);
    bit found;
    if ((!active || (n - 1 - t0) >= F + G) && en && (rq != 0)) begin
      found = 1'b0;
      for (int k = 1; k <= N; k++) begin
        int i;
        i = (rr + k) % N;
        if (!found && rq[i]) begin
          found = 1'b1;
          m_win = i;
        end
      end
      rr     = m_win;
      t0     = n;
      active = 1'b1;
      m_data = dat[7*m_win +: 7];
    end
  endtask

  task automatic compare_all();
    logic [N-1:0] eg, ea;
    logic ef, eb;
    int d;
    eg = '0; ea = '0; ef = 1'b0; eb = 1'b0;
    if (active) begin
      d = n - t0;
      if (d < F) begin
        eg = N'(1) << m_win;
        ef = 1'b1;
      end
      if (d == F) ea = N'(1) << m_win;
      eb = (d < F + G);
    end
    check("grant", 32'(grant), 32'(eg));
    check("ack", 32'(ack), 32'(ea));
    check("send_flag", 32'(send_flag), 32'(ef));
    check("busy", 32'(busy), 32'(eb));
    check("send_data", 32'(send_data), 32'(m_data));
  endtask

  task automatic step();
    logic en_s;
    logic [N-1:0] rq_s;
    logic [7*N-1:0] dat_s;
    en_s = enable; rq_s = req; dat_s = req_data;
    @(posedge clk);
    #1;
    n++;
    if (!rst_n) model_reset();
    else model_edge(en_s, rq_s, dat_s);
    compare_all();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req = '0;
    enable = 1'b1;
    #1;
    model_reset();
    compare_all();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    logic [N-1:0] exp_order [5];
    exp_order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

    // 1: single request, full frame and gap
    do_reset();
    req = 4'b0001; req_data = '0; req_data[6:0] = 7'h41;
    step();
    check("t1_grant", 32'(grant), 32'h1);
    check("t1_data", 32'(send_data), 32'h41);
    check("t1_flag", 32'(send_flag), 32'h1);
    repeat (F - 1) step();
    check("t1_flag_last", 32'(send_flag), 32'h1);
    step();
    check("t1_ack", 32'(ack), 32'h1);
    check("t1_flag_off", 32'(send_flag), 32'h0);
    req = '0;
    step();
    check("t1_ack_off", 32'(ack), 32'h0);
    check("t1_gap_busy", 32'(busy), 32'h1);
    step();
    check("t1_idle", 32'(busy), 32'h0);

    // 2: all requesting, round-robin order with 11-cycle period
    do_reset();
    req = 4'b1111;
    for (int i = 0; i < 4; i++) req_data[7*i +: 7] = 7'(8'h30 + i);
    for (int f = 0; f < 5; f++) begin
      step();
      check("t2_order", 32'(grant), 32'(exp_order[f]));
      if (f < 4) repeat (F + G) step();
    end

    // 3: wrap-around between requesters 0 and 2
    do_reset();
    req = 4'b0101;
    step();
    check("t3_g0", 32'(grant), 32'h1);
    repeat (F + G + 1) step();
    check("t3_g2", 32'(grant), 32'h4);
    repeat (F + G + 1) step();
    check("t3_g0b", 32'(grant), 32'h1);

    // 4: async reset mid-frame aborts; pointer restarts at requester 0
    do_reset();
    req = 4'b0001;
    step();
    repeat (4) step();
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("t4_flag", 32'(send_flag), 32'h0);
    check("t4_grant", 32'(grant), 32'h0);
    check("t4_busy", 32'(busy), 32'h0);
    compare_all();
    step();
    check("t4_no_ack", 32'(ack), 32'h0);
    rst_n = 1'b1;
    req = 4'b0011;
    step();
    check("t4_first", 32'(grant), 32'h1);

    // 5: enable drops mid-frame; frame completes, no regrant until enable
    do_reset();
    req = 4'b0010;
    step();
    repeat (2) step();
    enable = 1'b0;
    repeat (F - 2) step();
    check("t5_ack", 32'(ack), 32'h2);
    repeat (8) step();
    check("t5_hold", 32'(grant), 32'h0);
    check("t5_hold_busy", 32'(busy), 32'h0);
    enable = 1'b1;
    step();
    check("t5_regrant", 32'(grant), 32'h2);

    // 6: req withdrawn and data changed mid-frame
    do_reset();
    req = 4'b0010; req_data = '0; req_data[13:7] = 7'h55;
    step();
    step(); step();
    req = '0; req_data[13:7] = 7'h2A;
    repeat (F - 2) step();
    check("t6_ack", 32'(ack), 32'h2);
    check("t6_data", 32'(send_data), 32'h55);

    // Randomized traffic with occasional async resets
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (req[i]) req[i] = ($urandom_range(0, 9) != 0);
        else        req[i] = ($urandom_range(0, 4) == 0);
        if (ack[i]) req[i] = 1'b0;
      end
      enable   = ($urandom_range(0, 9) != 0);
      req_data = 28'($urandom);
      if ($urandom_range(0, 499) == 0) begin
        rst_n = 1'b0;
        #1;
        model_reset();
        compare_all();
        step();
        rst_n = 1'b1;
      end else begin
        step();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
